// File: rtl/mw8080_pkg.sv
// Shared types and helpers for the mw8080 input path (paddle pot emulation).
package mw8080_pkg;

  localparam int PAD_W = 8;

  typedef enum logic [0:0] {PAD_IDLE, PAD_MOVE} pad_state_t;

  // Direction as -1/0/+1; pressing both controls cancels out.
  function automatic logic signed [1:0] dir_of(input logic left, input logic right,
                                               input logic inv);
    logic signed [1:0] d;
    d = 2'sd0;
    if (right && !left) begin
      d = inv ? -2'sd1 : 2'sd1;
    end else if (left && !right) begin
      d = inv ? 2'sd1 : -2'sd1;
    end
    return d;
  endfunction

endpackage

// File: rtl/paddle_pot_emu_if.sv
// Bundle between the input mapper / CPU port (master) and the paddle emulator (slave).
interface paddle_pot_emu_if;
  import mw8080_pkg::*;

  logic             btn_left;
  logic             btn_right;
  logic             recentre;
  logic             VSync;
  logic [PAD_W-1:0] Paddle;
  logic             upd_stb;
  logic             at_stop;

  modport master (
    output btn_left, btn_right, recentre, VSync,
    input  Paddle, upd_stb, at_stop
  );

  modport slave (
    input  btn_left, btn_right, recentre, VSync,
    output Paddle, upd_stb, at_stop
  );
endinterface

// File: rtl/sync_edge.sv
// N-bit 2-flop synchroniser; bit 0 also gets a registered single-cycle rising-edge pulse.
module sync_edge #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] async_in,
  output logic [N-1:0] sync_out,
  output logic         rise
);

  logic [N-1:0] meta_reg;
  logic [N-1:0] sync_reg;
  logic         prev_reg;
  logic         rise_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= '0;
      sync_reg <= '0;
      prev_reg <= 1'b0;
      rise_reg <= 1'b0;
    end else begin
      meta_reg <= async_in;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg[0];
      rise_reg <= sync_reg[0] & ~prev_reg;
    end
  end

  assign sync_out = sync_reg;
  assign rise     = rise_reg;

endmodule

// File: rtl/paddle_pot_emu.sv
// Digital left/right to analog paddle pot emulation: per-frame motion with speed ramp and end-stop clamp.
module paddle_pot_emu
  import mw8080_pkg::*;
#(
  parameter logic [7:0] POS_MIN      = 8'd16,
  parameter logic [7:0] POS_MAX      = 8'd239,
  parameter logic [7:0] POS_CENTRE   = 8'd128,
  parameter logic [2:0] STEP_MIN     = 3'd1,
  parameter logic [2:0] STEP_MAX     = 3'd6,
  parameter logic [3:0] ACCEL_FRAMES = 4'd4,
  parameter logic       INVERT       = 1'b0
) (
  input logic              Clk,
  input logic              Rst_n,
  paddle_pot_emu_if.slave  pad
);

  generate
    if (POS_MIN > POS_MAX || POS_CENTRE < POS_MIN || POS_CENTRE > POS_MAX) begin : g_bad_range
      $error("paddle_pot_emu: POS_MIN/POS_MAX/POS_CENTRE out of order");
    end
    if (ACCEL_FRAMES == 4'd0 || STEP_MIN > STEP_MAX) begin : g_bad_step
      $error("paddle_pot_emu: ACCEL_FRAMES must be >=1 and STEP_MIN <= STEP_MAX");
    end
  endgenerate

  logic [3:0] sync_vec;
  logic       tick;
  logic       unused_vsync_sync;

  sync_edge #(.N(4)) u_sync (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .async_in ({pad.recentre, pad.btn_right, pad.btn_left, pad.VSync}),
    .sync_out (sync_vec),
    .rise     (tick)
  );

  assign unused_vsync_sync = sync_vec[0];

  pad_state_t        state_reg, state_next;
  logic [2:0]        step_reg, step_next;
  logic [3:0]        hold_reg, hold_next;
  logic signed [1:0] dir_reg;
  logic signed [1:0] dir_now;
  logic [7:0]        paddle_reg, paddle_next;
  logic              upd_reg;
  logic              stop_reg;
  logic              do_move;
  logic [9:0]        delta;
  logic [9:0]        sum;

  assign dir_now = dir_of(sync_vec[1], sync_vec[2], INVERT);

  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    hold_next  = hold_reg;
    do_move    = 1'b0;
    if (sync_vec[3]) begin
      state_next = PAD_IDLE;
      step_next  = 3'd0;
      hold_next  = 4'd0;
    end else begin
      case (state_reg)
        PAD_IDLE: begin
          if (dir_now != 2'sd0) begin
            state_next = PAD_MOVE;
            step_next  = STEP_MIN;
            hold_next  = 4'd0;
            do_move    = 1'b1;
          end
        end
        default: begin
          if (dir_now == 2'sd0) begin
            state_next = PAD_IDLE;
            step_next  = 3'd0;
            hold_next  = 4'd0;
          end else if (dir_now != dir_reg) begin
            step_next = STEP_MIN;
            hold_next = 4'd0;
            do_move   = 1'b1;
          end else if (hold_reg == ACCEL_FRAMES - 4'd1) begin
            // hold counter has completed a full accel period: bump the step
            hold_next = 4'd0;
            step_next = (step_reg >= STEP_MAX) ? STEP_MAX : step_reg + 3'd1;
            do_move   = 1'b1;
          end else begin
            hold_next = hold_reg + 4'd1;
            do_move   = 1'b1;
          end
        end
      endcase
    end
  end

  // Signed move in 10 bits, then clamp into the end-stops.
  always_comb begin
    delta = dir_now[1] ? -{7'd0, step_next} : {7'd0, step_next};
    sum   = {2'b00, paddle_reg} + delta;
    paddle_next = paddle_reg;
    if (sync_vec[3]) begin
      paddle_next = POS_CENTRE;
    end else if (do_move) begin
      if ($signed(sum) < $signed({2'b00, POS_MIN})) begin
        paddle_next = POS_MIN;
      end else if ($signed(sum) > $signed({2'b00, POS_MAX})) begin
        paddle_next = POS_MAX;
      end else begin
        paddle_next = sum[7:0];
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg  <= PAD_IDLE;
      step_reg   <= 3'd0;
      hold_reg   <= 4'd0;
      dir_reg    <= 2'sd0;
      paddle_reg <= POS_CENTRE;
      upd_reg    <= 1'b0;
      stop_reg   <= 1'b0;
    end else if (tick) begin
      state_reg  <= state_next;
      step_reg   <= step_next;
      hold_reg   <= hold_next;
      dir_reg    <= dir_now;
      paddle_reg <= paddle_next;
      upd_reg    <= (paddle_next != paddle_reg);
      stop_reg   <= (paddle_next == POS_MIN) || (paddle_next == POS_MAX);
    end else begin
      upd_reg <= 1'b0;
    end
  end

  assign pad.Paddle  = paddle_reg;
  assign pad.upd_stb = upd_reg;
  assign pad.at_stop = stop_reg;

endmodule
